mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Load/store sequencer between the pipeline MEM stage and port 2 of the data MEMORY
//  (big-endian, async read, sync write, always touches 4 bytes at address..address+3).
//  Performs byte/half/word loads with sign/zero extension.
//  Performs word stores directly.
//  Performs byte/half stores as a 2-cycle read-modify-write, because the port cannot
//  read while write-enabled.
//  Rejects illegal, out-of-range and (optionally) misaligned requests.
// PARAMETERS
//  NUM_BYTES    1024  size of attached memory in bytes; bounds check limit
//  ALIGN_CHECK  1     1: addr must be a multiple of access size; 0: any byte address allowed
// PORTS
//  clk              in     1   single clock; all state updates on posedge
//  rst              in     1   synchronous, active-high reset
//  req_valid        in     1   request present
//  req_ready        out    1   unit can accept; high only in IDLE
//  req_write        in     1   1 = store, 0 = load
//  req_size         in     2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned     in     1   loads: 1 = zero-extend, 0 = sign-extend
//  req_addr         in     32  byte address
//  req_wdata        in     32  store data, right-justified (byte in [7:0], half in [15:0])
//  resp_valid       out    1   response present; held until resp_ready
//  resp_ready       in     1   consumer accepts response
//  resp_rdata       out    32  load result; 0 for stores and errors
//  resp_error       out    1   request rejected; no memory write performed
//  mem_address      out    32  to MEMORY memory_address2
//  mem_write_enable out    1   to MEMORY memory_write_enable2
//  mem_data         inout  32  to MEMORY memory_data2; driven only while mem_write_enable=1, else 'z
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_error=0;
//   mem_write_enable=0; mem_address=0.
//  Accept: at the edge where req_valid&&req_ready (cycle T), register all req_* fields.
//   req_ready drops next cycle; inputs are ignored until IDLE is re-entered.
//  Check at accept; error if any of:
//   - size==11
//   - req_addr+4 > NUM_BYTES (compute in 33 bits; memory always touches 4 bytes)
//   - ALIGN_CHECK && ((half && addr[0]) || (word && addr[1:0]!=0))
//   On error: go to RESP with error=1, rdata=0, no memory access. resp_valid at T+1.
//  FSM transitions:
//   IDLE  ->ACCESS            on accepted legal request
//   IDLE  ->RESP              on error
//   ACCESS->RESP              for a load or a word store
//   ACCESS->MERGE             for a byte or half store
//   MERGE ->RESP
//   RESP  ->IDLE              on resp_ready
//  ACCESS (T+1):
//   - mem_address = addr.
//   - Load: mem_write_enable=0; capture mem_data at the edge, then extend:
//     byte = [31:24], half = [31:16], word = [31:0].
//   - Word store: mem_write_enable=1; mem_data = wdata; memory commits at the end of T+1.
//   - Byte/half store: mem_write_enable=0; capture the old word.
//  MERGE (T+2), byte/half store only: mem_write_enable=1; mem_address = addr;
//   mem_data = {wdata[7:0], old[23:0]} for byte, {wdata[15:0], old[15:0]} for half.
//  Response timing:
//   - load: resp_valid at T+2
//   - word store: resp_valid at T+2
//   - byte/half store: resp_valid at T+3
//  RESP: resp_valid=1; rdata and error held stable until the resp_ready edge;
//   req_ready=1 again the cycle after.
//  mem_write_enable is high for exactly one cycle per store and 0 in IDLE/RESP;
//   mem_address=0 outside ACCESS/MERGE.
//  Reset mid-operation: a write cycle coinciding with the reset edge still commits
//   (memory samples the same edge). No write occurs after reset; any pending
//   response is discarded.
// TESTING
//  1 mem[4..7]=80 12 34 56; load byte addr 4 signed -> resp_rdata=FFFFFF80 at T+2;
//    unsigned -> 00000080; mem_write_enable never high.
//  2 mem[8..11]=11 22 33 44; store byte wdata=000000AB addr 8 -> one cycle of
//    we=1 at T+2 driving AB223344; mem[8..11]=AB 22 33 44; resp at T+3 with error=0.
//  3 store word DEADBEEF addr 12 -> we=1 only at T+1; then load half addr 14
//    unsigned -> 0000BEEF.
//  4 load word addr 1021 -> resp_error=1 at T+1; resp_rdata=0; no we.
//    Half store addr 3 with ALIGN_CHECK=1 -> error, memory unchanged.
//  5 hold resp_ready=0 for 3 cycles -> resp_valid/resp_rdata stable; req_ready=0;
//    a new req_valid is not accepted until after the resp_ready edge.
//  6 assert rst during ACCESS of a byte store -> no we ever asserted; memory unchanged;
//    all outputs at reset values next cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the pipeline MEM stage and a big-endian, async-read,
// sync-write memory port; byte/half stores are done as a read-modify-write.
module mem_access_unit #(
  parameter int unsigned NUM_BYTES   = 1024,
  parameter int unsigned ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic        mem_write_enable,
  inout  wire  [31:0] mem_data
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_MERGE  = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            write_q, write_d;
  logic [1:0]      size_q, size_d;
  logic            unsigned_q, unsigned_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            error_q, error_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic            mem_we_q, mem_we_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

  logic            req_err_c;
  logic            misalign_c;
  logic            range_err_c;

  // Memory always touches 4 bytes, so the range check uses addr+4 in 33 bits.
  assign range_err_c = ({1'b0, req_addr} + 33'd4) > 33'(NUM_BYTES);
  assign misalign_c  = (ALIGN_CHECK != 0) &&
                       (((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)));
  assign req_err_c   = (req_size == SZ_ILL) || range_err_c || misalign_c;

  function automatic logic [DW-1:0] extend_load(input logic [1:0] size,
                                                input logic uns,
                                                input logic [DW-1:0] word);
    logic s;
    s = ~uns & word[31];
    case (size)
      SZ_BYTE: extend_load = {{24{s}}, word[31:24]};
      SZ_HALF: extend_load = {{16{s}}, word[31:16]};
      default: extend_load = word;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    error_d      = error_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    mem_addr_d   = '0;
    mem_we_d     = 1'b0;
    mem_wdata_d  = '0;

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          write_d     = req_write;
          size_d      = req_size;
          unsigned_d  = req_unsigned;
          addr_d      = req_addr;
          wdata_d     = req_wdata[15:0];
          rdata_d     = '0;
          req_ready_d = 1'b0;
          if (req_err_c) begin
            error_d      = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
          end else begin
            error_d     = 1'b0;
            mem_addr_d  = req_addr;
            mem_we_d    = req_write && (req_size == SZ_WORD);
            mem_wdata_d = req_wdata;
            state_d     = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (!write_q) begin
          rdata_d      = extend_load(size_q, unsigned_q, mem_data);
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else if (size_q == SZ_WORD) begin
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          // Old word is on the bus this cycle; merge new data into its top bytes.
          mem_addr_d  = addr_q;
          mem_we_d    = 1'b1;
          mem_wdata_d = (size_q == SZ_BYTE) ? {wdata_q[7:0], mem_data[23:0]}
                                            : {wdata_q[15:0], mem_data[15:0]};
          state_d     = S_MERGE;
        end
      end
      S_MERGE: begin
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
      default: begin
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      size_q       <= SZ_BYTE;
      unsigned_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      error_q      <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      error_q      <= error_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = rdata_q;
  assign resp_error       = error_q;
  assign mem_address      = mem_addr_q;
  assign mem_write_enable = mem_we_q;
  assign mem_data         = mem_we_q ? mem_wdata_q : {DW{1'bz}};

endmodule
